// File: rtl/led_mmio_port.sv
// Memory-mapped LED port: LED register with set/clear/toggle aliases and a blink engine.
// Optional LED_PWM_EN adds a duty-cycle register at 0x1C gating every LED output.
module led_mmio_port #(
  parameter logic [31:0]       BASE_ADDR = 32'h0000_1000,
  parameter int unsigned       N_LEDS    = 8,
  parameter logic [N_LEDS-1:0] LED_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic [N_LEDS-1:0] leds
);

  logic [N_LEDS-1:0] led_q, led_d, mask_q, mask_d, leds_q, leds_d;
  logic [23:0]       div_q, div_d, cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic              ack_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              start, hit, wr, div_wr;
  logic [2:0]        off;
  logic [N_LEDS-1:0] wd;

`ifdef LED_PWM_EN
  logic [7:0] pwm_q, pwm_d, pcnt_q, pcnt_d;
`endif

  // A request still high in the ack cycle is not a new transaction yet.
  assign start = req & ~ack_q;
  assign hit   = (addr[31:5] == BASE_ADDR[31:5]);
  assign off   = addr[4:2];
  assign wr    = start & we & hit;
  assign wd    = wdata[N_LEDS-1:0];

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:24]};

  always_comb begin
    led_d  = led_q;
    mask_d = mask_q;
    div_d  = div_q;
    div_wr = 1'b0;
`ifdef LED_PWM_EN
    pwm_d  = pwm_q;
`endif
    if (wr) begin
      case (off)
        3'd0: led_d  = wd;
        3'd1: led_d  = led_q | wd;
        3'd2: led_d  = led_q & ~wd;
        3'd3: led_d  = led_q ^ wd;
        3'd4: mask_d = wd;
        3'd5: begin
          div_d  = wdata[23:0];
          div_wr = 1'b1;
        end
`ifdef LED_PWM_EN
        3'd7: pwm_d  = wdata[7:0];
`endif
        default: ;
      endcase
    end
  end

  // Blink counter; a divider write restarts the period from phase 0.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (div_wr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (div_q == 24'd0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == div_q - 24'd1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + 24'd1;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (start && !we && hit) begin
      case (off)
        3'd0, 3'd1, 3'd2, 3'd3: rdata_d[N_LEDS-1:0] = led_q;
        3'd4:                   rdata_d[N_LEDS-1:0] = mask_q;
        3'd5:                   rdata_d[23:0]       = div_q;
        3'd6:                   rdata_d[0]          = phase_q;
`ifdef LED_PWM_EN
        3'd7:                   rdata_d[7:0]        = pwm_q;
`endif
        default: ;
      endcase
    end
  end

`ifdef LED_PWM_EN
  assign pcnt_d = pcnt_q + 8'd1;
  always_comb begin
    leds_d = led_d ^ (mask_d & {N_LEDS{phase_d}});
    if (!(pcnt_d < pwm_d)) leds_d = '0;
  end
`else
  always_comb begin
    leds_d = led_d ^ (mask_d & {N_LEDS{phase_d}});
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      led_q   <= LED_RESET;
      mask_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      leds_q  <= LED_RESET;
    end else begin
      ack_q   <= start;
      rdata_q <= rdata_d;
      led_q   <= led_d;
      mask_q  <= mask_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      leds_q  <= leds_d;
    end
  end

`ifdef LED_PWM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_q  <= 8'hFF;
      pcnt_q <= '0;
    end else begin
      pwm_q  <= pwm_d;
      pcnt_q <= pcnt_d;
    end
  end
`endif

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign leds  = leds_q;

endmodule

// File: tb/tb_led_mmio_port.sv
// Self-checking bench for led_mmio_port: directed steps plus randomized accesses checked
// against a cycle-count based reference model.
module tb_led_mmio_port;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ack;
  logic [7:0]  leds;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_mmio_port #(
    .BASE_ADDR(BASE),
    .N_LEDS   (8),
    .LED_RESET(8'h00)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .ack  (ack),
    .leds (leds)
  );

  // Clock edges since reset release; blink phase and PWM are derived from it.
  int unsigned n_edge;
  always @(posedge clk or posedge rst) begin
    if (rst) n_edge <= 0;
    else     n_edge <= n_edge + 1;
  end

  logic [7:0]  m_led, m_mask, m_pwm;
  logic [23:0] m_div;
  int unsigned m_div_edge;

  function automatic logic m_phase(input int unsigned e);
    if (m_div == 24'd0) return 1'b0;
    return (((e - m_div_edge) / m_div) % 2) == 1;
  endfunction

  function automatic logic [7:0] m_leds();
    logic [7:0] v;
    v = m_led ^ (m_mask & {8{m_phase(n_edge)}});
`ifdef LED_PWM_EN
    if (!((n_edge % 256) < m_pwm)) v = 8'h00;
`endif
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'h0;
    case (a[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: return {24'h0, m_led};
      3'd4: return {24'h0, m_mask};
      3'd5: return {8'h0, m_div};
      3'd6: return {31'h0, m_phase(n_edge)};
`ifdef LED_PWM_EN
      3'd7: return {24'h0, m_pwm};
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d);
    if (a[31:5] == BASE[31:5]) begin
      case (a[4:2])
        3'd0: m_led  = d[7:0];
        3'd1: m_led  = m_led | d[7:0];
        3'd2: m_led  = m_led & ~d[7:0];
        3'd3: m_led  = m_led ^ d[7:0];
        3'd4: m_mask = d[7:0];
        3'd5: begin
          m_div      = d[23:0];
          m_div_edge = n_edge;
        end
`ifdef LED_PWM_EN
        3'd7: m_pwm  = d[7:0];
`endif
        default: ;
      endcase
    end
  endtask

  task automatic m_reset();
    m_led = 8'h00; m_mask = 8'h00; m_div = 24'd0; m_div_edge = 0; m_pwm = 8'hFF;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge with ack low; ends #1 after the edge that drops ack.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
    logic [31:0] exp_rd;
    exp_rd = w ? 32'h0 : m_read(a);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    if (w) m_write(a, d);
    rd = rdata;
    chk("ack_high", {31'h0, ack}, 32'h1);
    chk("rdata", rdata, exp_rd);
    chk("leds_at_ack", {24'h0, leds}, {24'h0, m_leds()});
    req = 1'b0;
    @(posedge clk); #1;
    chk("ack_low", {31'h0, ack}, 32'h0);
    chk("rdata_idle", rdata, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("leds_idle", {24'h0, leds}, {24'h0, m_leds()});
      chk("ack_idle", {31'h0, ack}, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic [7:0]  vals [3];
    int          sel, cnt_on;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    m_reset();
    #1;
    chk("reset_leds", {24'h0, leds}, 32'h0);
    chk("reset_ack", {31'h0, ack}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    #21 rst = 1'b0;
    @(posedge clk); #1;

    // LED write visible on the ack edge
    access(1'b1, BASE + 32'h00, 32'h0000_00A5, rd);
    chk("t1_leds", {24'h0, leds}, 32'hA5);

    // Aliases from zero
    access(1'b1, BASE + 32'h00, 32'h0, rd);
    access(1'b1, BASE + 32'h04, 32'hFFFF_FF0F & 32'h0000_000F, rd);
    chk("t2_set", {24'h0, leds}, 32'h0F);
    access(1'b1, BASE + 32'h08, 32'h0000_0081, rd);
    chk("t2_clr", {24'h0, leds}, 32'h0E);
    access(1'b1, BASE + 32'h0C, 32'h0000_00FF, rd);
    chk("t2_tgl", {24'h0, leds}, 32'hF1);
    access(1'b0, BASE + 32'h04, 32'h0, rd);
    chk("t2_read_set", rd, 32'hF1);

    // Blink with divider 4
    access(1'b1, BASE + 32'h10, 32'h01, rd);
    access(1'b1, BASE + 32'h14, 32'h04, rd);
    access(1'b1, BASE + 32'h00, 32'h00, rd);
    idle(17);
    access(1'b0, BASE + 32'h18, 32'h0, rd);
    access(1'b1, BASE + 32'h14, 32'h00, rd);
    chk("t3_led0_off", {31'h0, leds[0]}, 32'h0);
    access(1'b0, BASE + 32'h18, 32'h0, rd);
    chk("t3_stat_zero", rd, 32'h0);

    // Unmapped accesses
    access(1'b1, BASE + 32'h00, 32'h3C, rd);
`ifndef LED_PWM_EN
    access(1'b0, BASE + 32'h1C, 32'h0, rd);
    chk("t4_rd_1c", rd, 32'h0);
    access(1'b1, BASE + 32'h1C, 32'hFF, rd);
`endif
    access(1'b0, BASE + 32'h40, 32'h0, rd);
    chk("t4_rd_40", rd, 32'h0);
    access(1'b1, BASE + 32'h40, 32'hFF, rd);
    access(1'b1, BASE + 32'h18, 32'hFF, rd);
    chk("t4_leds_kept", {24'h0, leds}, 32'h3C);

    // Req held high: one access every two cycles
    access(1'b1, BASE + 32'h00, 32'h00, rd);
    vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h04;
    req = 1'b1; we = 1'b1; addr = BASE + 32'h04;
    for (int s = 0; s < 6; s++) begin
      wdata = {24'h0, vals[s/2]};
      @(posedge clk); #1;
      if (s % 2 == 0) m_write(BASE + 32'h04, {24'h0, vals[s/2]});
      chk("t5_ack", {31'h0, ack}, {31'h0, (s % 2 == 0)});
      chk("t5_leds", {24'h0, leds}, {24'h0, m_leds()});
    end
    req = 1'b0;
    chk("t5_three_writes", {24'h0, leds}, 32'h07);
    idle(1);

    // Randomized accesses
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 8);
      if (sel == 8) a = $urandom;
      else          a = BASE + 32'(sel * 4) + 32'($urandom_range(0, 3));
      d = $urandom;
      if (sel == 5) d = (d & 32'hFF00_0000) | 32'($urandom_range(0, 5));
      access($urandom_range(0, 1) == 1, a, d, rd);
      idle($urandom_range(0, 4));
    end

    // Reset during blink and during a pending request
    access(1'b1, BASE + 32'h00, 32'hA5, rd);
    access(1'b1, BASE + 32'h10, 32'hFF, rd);
    access(1'b1, BASE + 32'h14, 32'h03, rd);
    idle(4);
    req = 1'b1; we = 1'b1; addr = BASE; wdata = 32'h3C;
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("t6_rst_leds", {24'h0, leds}, 32'h00);
    chk("t6_rst_ack", {31'h0, ack}, 32'h0);
    @(posedge clk); #1;
    chk("t6_rst_hold_ack", {31'h0, ack}, 32'h0);
    #2 rst = 1'b0; req = 1'b0;
    idle(3);

`ifdef LED_PWM_EN
    access(1'b1, BASE + 32'h00, 32'hFF, rd);
    access(1'b1, BASE + 32'h1C, 32'h40, rd);
    cnt_on = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      chk("pwm_leds", {24'h0, leds}, {24'h0, m_leds()});
      if (leds[0]) cnt_on++;
    end
    chk("pwm_duty", 32'(cnt_on), 32'd64);
`else
    cnt_on = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
